// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write-to-read forwarding
// and a per-register busy scoreboard set by issue and cleared by writeback.
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr_i,
  output logic [NRD*XLEN-1:0]   rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic [NWR-1:0]        wr_en_i,
  input  logic [NWR*AW-1:0]     wr_addr_i,
  input  logic [NWR*XLEN-1:0]   wr_data_i,
  input  logic                  alloc_en_i,
  input  logic [AW-1:0]         alloc_addr_i,
  input  logic                  flush_i,
  output logic [NREGS-1:0]      busy_vec_o
);

  logic [XLEN-1:0]  regs_reg  [NREGS];
  logic [XLEN-1:0]  regs_next [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Later write ports overwrite earlier ones, so the highest-index port wins.
  always_comb begin
    logic hit;
    hit       = 1'b0;
    busy_next = busy_reg;
    for (int r = 0; r < NREGS; r++) begin
      regs_next[r] = regs_reg[r];
      hit          = 1'b0;
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
          hit          = 1'b1;
          regs_next[r] = wr_data_i[p*XLEN +: XLEN];
        end
      end
      // A new producer supersedes a completing older one.
      if (flush_i)
        busy_next[r] = 1'b0;
      else if (alloc_en_i && (alloc_addr_i == AW'(r)))
        busy_next[r] = 1'b1;
      else if (hit)
        busy_next[r] = 1'b0;
      else
        busy_next[r] = busy_reg[r];
    end
    if (ZERO_REG != 0) begin
      regs_next[0] = '0;
      busy_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs_reg[r] <= '0;
      busy_reg <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        regs_reg[r] <= regs_next[r];
      busy_reg <= busy_next;
    end
  end

  assign busy_vec_o = busy_reg;

  // Read ports: hardwired zero, then forwarding, then stored state.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr_i[gi*AW +: AW];

    always_comb begin
      logic            fwd_hit;
      logic [XLEN-1:0] fwd_data;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = wr_data_i[p*XLEN +: XLEN];
        end
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end else if (fwd_hit) begin
        data = fwd_data;
        busy = 1'b0;
      end else begin
        data = regs_reg[addr];
        busy = busy_reg[addr];
      end
    end

    assign rd_data_o[gi*XLEN +: XLEN] = data;
    assign rd_busy_o[gi]              = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a dual-write default-size instance driven from a
// vector table, plus a small ZERO_REG=0 instance for the parameter sweep.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: XLEN=64, NREGS=32, NRD=2, NWR=2, ZERO_REG=1
  logic [9:0]   m_rd_addr;
  logic [127:0] m_rd_data;
  logic [1:0]   m_rd_busy;
  logic [1:0]   m_wr_en;
  logic [9:0]   m_wr_addr;
  logic [127:0] m_wr_data;
  logic         m_alloc_en;
  logic [4:0]   m_alloc_addr;
  logic         m_flush;
  logic [31:0]  m_busy_vec;

  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) u_main (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(m_rd_addr), .rd_data_o(m_rd_data), .rd_busy_o(m_rd_busy),
    .wr_en_i(m_wr_en), .wr_addr_i(m_wr_addr), .wr_data_i(m_wr_data),
    .alloc_en_i(m_alloc_en), .alloc_addr_i(m_alloc_addr), .flush_i(m_flush),
    .busy_vec_o(m_busy_vec)
  );

  // Sweep instance: XLEN=32, NREGS=16, NRD=3, NWR=1, ZERO_REG=0
  logic [11:0] s_rd_addr;
  logic [95:0] s_rd_data;
  logic [2:0]  s_rd_busy;
  logic [0:0]  s_wr_en;
  logic [3:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic        s_alloc_en;
  logic [3:0]  s_alloc_addr;
  logic        s_flush;
  logic [15:0] s_busy_vec;

  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1), .ZERO_REG(0)) u_sweep (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data), .rd_busy_o(s_rd_busy),
    .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data),
    .alloc_en_i(s_alloc_en), .alloc_addr_i(s_alloc_addr), .flush_i(s_flush),
    .busy_vec_o(s_busy_vec)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        al;
    logic [4:0]  aa;
    logic        fl;
    logic [63:0] e0;
    logic [63:0] e1;
    logic        eb0;
    logic        eb1;
    logic [31:0] ebv;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  logic [63:0] exp_q [$];
  int n_run  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input int we, input int wa0, input logic [63:0] wd0,
                              input int wa1, input logic [63:0] wd1,
                              input int ra0, input int ra1,
                              input int al, input int aa, input int fl,
                              input logic [63:0] e0, input logic [63:0] e1,
                              input int eb0, input int eb1, input int ebv);
    vec_t v;
    v.we  = 2'(we);  v.wa0 = 5'(wa0); v.wd0 = wd0; v.wa1 = 5'(wa1); v.wd1 = wd1;
    v.ra0 = 5'(ra0); v.ra1 = 5'(ra1); v.al = 1'(al); v.aa = 5'(aa);  v.fl = 1'(fl);
    v.e0  = e0; v.e1 = e1; v.eb0 = 1'(eb0); v.eb1 = 1'(eb1); v.ebv = 32'(ebv);
    return v;
  endfunction

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic observe(input string what, input logic [63:0] act);
    logic [63:0] e;
    n_run++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: actual %h, scoreboard had no expected value", what, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: actual %h required %h", what, act, e);
      end
    end
  endtask

  task automatic idle_inputs();
    m_rd_addr = '0; m_wr_en = '0; m_wr_addr = '0; m_wr_data = '0;
    m_alloc_en = 1'b0; m_alloc_addr = '0; m_flush = 1'b0;
    s_rd_addr = '0; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0;
    s_alloc_en = 1'b0; s_alloc_addr = '0; s_flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();

    // Reset state, held before any clock edge
    #2;
    expect_val(64'd0); expect_val(64'd0); expect_val(64'd0);
    observe("reset_rd0", m_rd_data[63:0]);
    observe("reset_rd1", m_rd_data[127:64]);
    observe("reset_busy_vec", {32'd0, m_busy_vec});
    $display("[TB] reset: rd0=%h rd1=%h busy_vec=%h", m_rd_data[63:0], m_rd_data[127:64], m_busy_vec);
    @(negedge clk);
    rst_n = 1'b1;

    //            we  wa0 wd0      wa1 wd1      ra0 ra1 al aa fl  e0       e1       b0 b1 busy_vec
    vecs[0]  = mk(3,  5, 'hAAAA,   5, 'hBBBB,   5,  5,  0, 0, 0, 'hBBBB,  'hBBBB,  0, 0, 'h000);
    vecs[1]  = mk(0,  0, 0,        0, 0,        5,  5,  0, 0, 0, 'hBBBB,  'hBBBB,  0, 0, 'h000);
    vecs[2]  = mk(1,  0, 'hFFFF,   0, 0,        0,  0,  0, 0, 0, 0,       0,       0, 0, 'h000);
    vecs[3]  = mk(0,  0, 0,        0, 0,        0,  5,  1, 7, 0, 0,       'hBBBB,  0, 0, 'h080);
    vecs[4]  = mk(0,  0, 0,        0, 0,        7,  5,  0, 0, 0, 0,       'hBBBB,  1, 0, 'h080);
    vecs[5]  = mk(1,  7, 'h1234,   0, 0,        7,  7,  0, 0, 0, 'h1234,  'h1234,  0, 0, 'h000);
    vecs[6]  = mk(0,  0, 0,        0, 0,        7,  0,  0, 0, 0, 'h1234,  0,       0, 0, 'h000);
    vecs[7]  = mk(2,  0, 0,        9, 'h55,     9,  9,  1, 9, 0, 'h55,    'h55,    0, 0, 'h200);
    vecs[8]  = mk(0,  0, 0,        0, 0,        9,  9,  0, 0, 0, 'h55,    'h55,    1, 1, 'h200);
    vecs[9]  = mk(0,  0, 0,        0, 0,        0,  9,  1, 0, 0, 0,       'h55,    0, 1, 'h200);
    vecs[10] = mk(0,  0, 0,        0, 0,        1,  2,  1, 1, 0, 0,       0,       0, 0, 'h202);
    vecs[11] = mk(0,  0, 0,        0, 0,        1,  2,  1, 2, 0, 0,       0,       1, 0, 'h206);
    vecs[12] = mk(0,  0, 0,        0, 0,        2,  3,  1, 3, 0, 0,       0,       1, 0, 'h20E);
    vecs[13] = mk(0,  0, 0,        0, 0,        3,  4,  1, 4, 0, 0,       0,       1, 0, 'h21E);
    vecs[14] = mk(0,  0, 0,        0, 0,        4, 10,  1,10, 1, 0,       0,       1, 0, 'h000);
    vecs[15] = mk(0,  0, 0,        0, 0,        5,  9,  0, 0, 0, 'hBBBB,  'h55,    0, 0, 'h000);
    vecs[16] = mk(3,  3, 'h11,     4, 'h22,     3,  4,  0, 0, 0, 'h11,    'h22,    0, 0, 'h000);
    vecs[17] = mk(0,  0, 0,        0, 0,        3,  4,  0, 0, 0, 'h11,    'h22,    0, 0, 'h000);
    vecs[18] = mk(2,  5, 'h99,     5, 'h77,     5,  5,  0, 0, 0, 'h77,    'h77,    0, 0, 'h000);
    vecs[19] = mk(0,  0, 0,        0, 0,        5,  7,  0, 0, 0, 'h77,    'h1234,  0, 0, 'h000);
    vecs[20] = mk(1,  6, 'h66,     6, 'hEE,     6,  6,  0, 0, 0, 'h66,    'h66,    0, 0, 'h000);
    vecs[21] = mk(0,  0, 0,        0, 0,        6,  5,  0, 0, 0, 'h66,    'h77,    0, 0, 'h000);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      m_wr_en      = vecs[i].we;
      m_wr_addr    = {vecs[i].wa1, vecs[i].wa0};
      m_wr_data    = {vecs[i].wd1, vecs[i].wd0};
      m_rd_addr    = {vecs[i].ra1, vecs[i].ra0};
      m_alloc_en   = vecs[i].al;
      m_alloc_addr = vecs[i].aa;
      m_flush      = vecs[i].fl;
      expect_val(vecs[i].e0);
      expect_val(vecs[i].e1);
      expect_val({63'd0, vecs[i].eb0});
      expect_val({63'd0, vecs[i].eb1});
      expect_val({32'd0, vecs[i].ebv});
      #1;
      observe($sformatf("vec%0d_rd0", i), m_rd_data[63:0]);
      observe($sformatf("vec%0d_rd1", i), m_rd_data[127:64]);
      observe($sformatf("vec%0d_busy0", i), {63'd0, m_rd_busy[0]});
      observe($sformatf("vec%0d_busy1", i), {63'd0, m_rd_busy[1]});
      @(posedge clk);
      #1;
      observe($sformatf("vec%0d_busy_vec", i), {32'd0, m_busy_vec});
      $display("[TB] vec %0d: rd0=%h rd1=%h busy=%b busy_vec=%h",
               i, m_rd_data[63:0], m_rd_data[127:64], m_rd_busy, m_busy_vec);
    end
    @(negedge clk);
    idle_inputs();

    // Parameter sweep: r0 is an ordinary register when ZERO_REG=0
    @(negedge clk);
    s_wr_en = 1'b1; s_wr_addr = 4'd0; s_wr_data = 32'hDEAD;
    s_rd_addr = 12'h000;
    expect_val(64'hDEAD);
    #1;
    observe("sweep_fwd_r0", {32'd0, s_rd_data[31:0]});
    $display("[TB] sweep write r0: rd0=%h", s_rd_data[31:0]);
    @(negedge clk);
    s_wr_en = 1'b0; s_alloc_en = 1'b1; s_alloc_addr = 4'd0;
    expect_val(64'hDEAD); expect_val(64'd0);
    #1;
    observe("sweep_read_r0", {32'd0, s_rd_data[95:64]});
    observe("sweep_busy_pre_alloc", {63'd0, s_rd_busy[2]});
    @(posedge clk);
    #1;
    expect_val(64'h1);
    observe("sweep_busy_vec_r0", {48'd0, s_busy_vec});
    @(negedge clk);
    s_alloc_en = 1'b0;
    expect_val(64'd1);
    #1;
    observe("sweep_rd_busy_r0", {63'd0, s_rd_busy[1]});
    $display("[TB] sweep alloc r0: busy_vec=%h rd_busy=%b", s_busy_vec, s_rd_busy);

    // Asynchronous reset asserted mid-cycle after live state
    @(negedge clk);
    m_alloc_en = 1'b1; m_alloc_addr = 5'd20;
    m_wr_en = 2'b01; m_wr_addr = {5'd0, 5'd21}; m_wr_data = {64'd0, 64'hCAFE};
    @(posedge clk);
    #1;
    expect_val(64'h0010_0000);
    observe("pre_reset_busy_vec", {32'd0, m_busy_vec});
    @(negedge clk);
    idle_inputs();
    m_wr_en = 2'b10; m_wr_addr = {5'($urandom_range(1, 31)), 5'd0};
    m_wr_data = {64'($urandom), 64'd0};
    #2;
    rst_n = 1'b0;
    m_wr_en = '0;
    #1;
    expect_val(64'd0);
    observe("async_reset_busy_vec", {32'd0, m_busy_vec});
    for (int a = 0; a < 32; a++) begin
      m_rd_addr = {5'(a), 5'(a)};
      expect_val(64'd0);
      #1;
      observe($sformatf("async_reset_r%0d", a), m_rd_data[63:0]);
    end
    $display("[TB] async reset: busy_vec=%h all registers read back", m_busy_vec);
    m_wr_en = 2'b01; m_wr_addr = {5'd0, 5'd8}; m_wr_data = {64'd0, 64'h5A};
    m_rd_addr = {5'd8, 5'd8};
    expect_val(64'h5A); expect_val(64'd0);
    #1;
    observe("reset_fwd_r8", m_rd_data[63:0]);
    observe("reset_fwd_busy", {63'd0, m_rd_busy[0]});
    $display("[TB] reset forwarding: rd0=%h", m_rd_data[63:0]);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    if (exp_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
